// File: rtl/tx_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tx_frame_scheduler
//
// Serial-transmit controller sitting in front of a 10-bit PISO shift register.
// Two byte requesters are arbitrated round-robin. The winning byte is framed
// as {start, d[0]..d[7], stop}, with bit 9 sent first. The frame is handed to
// the PISO with a one-cycle load pulse. One shift strobe per bit-time then
// follows, timed by an internal baud counter. An optional idle gap can be
// inserted after each frame.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   req_a_valid  requester A has a byte (held until accepted)
//   req_a_data   requester A byte
//   req_a_ready  A accepted this cycle (combinational, IDLE only)
//   req_b_valid  requester B has a byte (held until accepted)
//   req_b_data   requester B byte
//   req_b_ready  B accepted this cycle (combinational, IDLE only)
//   piso_data    framed word for the PISO parallel input, held between loads
//   piso_load    one-cycle parallel-load pulse
//   piso_shift   one-cycle shift strobe, one per bit-time
//   busy         frame or trailing gap in progress
//   grant_b      owner of the current/last frame (0 = A, 1 = B)
//   frame_done   one-cycle pulse coincident with the final (stop) strobe
// ---------------------------------------------------------------------------
module tx_frame_scheduler #(
  parameter int CLKS_PER_BIT = 434,
  parameter int GAP_BITS     = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_a_valid,
  input  logic [7:0] req_a_data,
  output logic       req_a_ready,
  input  logic       req_b_valid,
  input  logic [7:0] req_b_data,
  output logic       req_b_ready,
  output logic [9:0] piso_data,
  output logic       piso_load,
  output logic       piso_shift,
  output logic       busy,
  output logic       grant_b,
  output logic       frame_done
);

  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic              last_b;

  // Start bit (0) leads, data LSB-first, stop bit (1) last.
  function automatic logic [9:0] build_frame(input logic [7:0] d);
    logic [9:0] f;
    f[9] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[8-i] = d[i];
    end
    f[0] = 1'b1;
    return f;
  endfunction

  // Round-robin: on contention the requester not granted last wins.
  always_comb begin
    req_a_ready = 1'b0;
    req_b_ready = 1'b0;
    if (state == IDLE) begin
      if (req_a_valid && (!req_b_valid || last_b)) begin
        req_a_ready = 1'b1;
      end else if (req_b_valid) begin
        req_b_ready = 1'b1;
      end
    end
  end

  // Pulses are registered. So strobe and frame_done are set one cycle ahead,
  // when the baud counter sits just before its terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      piso_data  <= 10'h3FF;
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      grant_b    <= 1'b0;
      last_b     <= 1'b1;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      piso_load  <= 1'b0;
      piso_shift <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_a_ready) begin
            piso_data <= build_frame(req_a_data);
            grant_b   <= 1'b0;
            last_b    <= 1'b0;
            piso_load <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end else if (req_b_ready) begin
            piso_data <= build_frame(req_b_data);
            grant_b   <= 1'b1;
            last_b    <= 1'b1;
            piso_load <= 1'b1;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end

        LOAD: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          state    <= SHIFT;
        end

        SHIFT: begin
          if (baud_cnt == BAUD_LAST) begin
            // This cycle carries a strobe; the 10th one ends the frame.
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) begin
              if (GAP_BITS > 0) begin
                gap_cnt <= '0;
                state   <= GAP;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end else begin
            baud_cnt   <= baud_cnt + BAUD_W'(1);
            piso_shift <= (baud_cnt == BAUD_PRE);
            frame_done <= (baud_cnt == BAUD_PRE) && (bit_cnt == 4'd9);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
